// File: rtl/regfile_param.sv
// ============================================================================
// regfile_param : 2R/1W byte-enabled register file with write bypass,
//                 optional zero register and sequential bulk-clear engine.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                reg_write,
    input  logic [ADDR_W-1:0]   dir_WR,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   dirA,
    input  logic [ADDR_W-1:0]   dirB,
    output logic [DATA_W-1:0]   datA,
    output logic [DATA_W-1:0]   datB,
    output logic                rd_valid,
    input  logic                clr_req,
    output logic                busy
);

    localparam int          c_DEPTH = 1 << ADDR_W;
    localparam int          c_NB    = DATA_W / 8;
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(c_DEPTH - 1);

    localparam logic [0:0]  S_IDLE  = 1'b0;
    localparam logic [0:0]  S_CLEAR = 1'b1;

    logic [DATA_W-1:0] r_regs [c_DEPTH];
    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic              w_clr_step;
    logic              w_wr_acc;
    logic              w_wr_en;
    logic              w_rd_acc;
    logic [DATA_W-1:0] w_effA;
    logic [DATA_W-1:0] w_effB;

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (clr_req)          w_state_nxt = S_CLEAR;
            S_CLEAR: if (r_cnt == c_LAST)  w_state_nxt = S_IDLE;
            default:                       w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        w_clr_step = 1'b0;
        if (r_state == S_CLEAR) begin
            busy       = 1'b1;
            w_clr_step = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_clr_step) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (clr_req) begin
            r_cnt <= '0;
        end
    end

    // ---------------- access qualification ----------------
    assign w_wr_acc = reg_write && !busy;
    assign w_rd_acc = rd_en && !busy;
    assign w_wr_en  = w_wr_acc && !((ZERO_REG != 0) && (dir_WR == '0));

    // Effective read value: stored word overlaid with same-edge enabled bytes
    always_comb begin
        w_effA = r_regs[dirA];
        w_effB = r_regs[dirB];
        for (int b = 0; b < c_NB; b++) begin
            if (w_wr_acc && wr_be[b]) begin
                if (dirA == dir_WR) w_effA[8*b +: 8] = data_in[8*b +: 8];
                if (dirB == dir_WR) w_effB[8*b +: 8] = data_in[8*b +: 8];
            end
        end
        if ((ZERO_REG != 0) && (dirA == '0)) w_effA = '0;
        if ((ZERO_REG != 0) && (dirB == '0)) w_effB = '0;
    end

    // ---------------- storage ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) r_regs[i] <= '0;
        end else if (w_clr_step) begin
            r_regs[r_cnt] <= '0;
        end else if (w_wr_en) begin
            for (int b = 0; b < c_NB; b++) begin
                if (wr_be[b]) r_regs[dir_WR][8*b +: 8] <= data_in[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            datA     <= '0;
            datB     <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                datA <= w_effA;
                datB <= w_effB;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_param.sv
// ============================================================================
// tb_regfile_param : directed self-checking bench for regfile_param.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_param;

    logic        clk;
    logic        rst_n;
    logic        reg_write;
    logic [3:0]  dir_WR;
    logic [31:0] data_in;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [3:0]  dirA;
    logic [3:0]  dirB;
    logic        clr_req;
    logic [31:0] datA,  datB,  datA_nz, datB_nz;
    logic        rd_valid, busy, rd_valid_nz, busy_nz;

    int n_checks = 0;
    int n_fail   = 0;
    int n;

    regfile_param #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .dir_WR(dir_WR),
        .data_in(data_in), .wr_be(wr_be), .rd_en(rd_en), .dirA(dirA), .dirB(dirB),
        .datA(datA), .datB(datB), .rd_valid(rd_valid), .clr_req(clr_req), .busy(busy)
    );

    regfile_param #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(0)) u_dut_nz (
        .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .dir_WR(dir_WR),
        .data_in(data_in), .wr_be(wr_be), .rd_en(rd_en), .dirA(dirA), .dirB(dirB),
        .datA(datA_nz), .datB(datB_nz), .rd_valid(rd_valid_nz), .clr_req(clr_req),
        .busy(busy_nz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_write = 0; rd_en = 0; clr_req = 0; wr_be = 4'h0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        reg_write = 1; dir_WR = a; data_in = d; wr_be = be;
        tick();
        idle();
    endtask

    task automatic rd(input logic [3:0] a, input logic [3:0] b);
        rd_en = 1; dirA = a; dirB = b;
        tick();
        idle();
    endtask

    initial begin
        rst_n = 0; dir_WR = 0; data_in = 0; dirA = 0; dirB = 0;
        idle();
        repeat (2) tick();
        rst_n = 1;
        tick();

        // preload, then asynchronous reset must wipe everything
        for (int i = 0; i < 16; i++) wr(4'(i), 32'hDEADBEEF, 4'hF);
        rd(4'd3, 4'd7);
        check("preload_A", datA, 32'hDEADBEEF);
        check("preload_B", datB, 32'hDEADBEEF);
        #2 rst_n = 0;
        #1;
        check("rst_datA", datA, 32'h0);
        check("rst_valid", {31'b0, rd_valid}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        tick();
        rst_n = 1;
        tick();
        rd(4'd3, 4'd7);
        check("rst_rd_A", datA, 32'h0);
        check("rst_rd_B", datB, 32'h0);
        check("rst_rd_valid", {31'b0, rd_valid}, 32'h1);

        // byte-enabled write merge, wr_be=0 is a no-op, rd_en=0 holds data
        wr(4'd5, 32'h11223344, 4'hF);
        wr(4'd5, 32'hAABBCCDD, 4'b0101);
        rd(4'd5, 4'd5);
        check("byte_merge", datA, 32'h11BB33DD);
        wr(4'd5, 32'hFFFFFFFF, 4'h0);
        rd(4'd5, 4'd3);
        check("be_zero", datA, 32'h11BB33DD);
        check("be_zero_B", datB, 32'h0);
        tick();
        check("no_rd_valid", {31'b0, rd_valid}, 32'h0);
        check("no_rd_hold", datA, 32'h11BB33DD);

        // same-edge bypass, full and partial
        reg_write = 1; dir_WR = 4'd9; data_in = 32'h12345678; wr_be = 4'hF;
        rd_en = 1; dirA = 4'd9; dirB = 4'd9;
        tick(); idle();
        check("bypass_A", datA, 32'h12345678);
        check("bypass_B", datB, 32'h12345678);
        reg_write = 1; dir_WR = 4'd9; data_in = 32'hAABBCCDD; wr_be = 4'b1000;
        rd_en = 1; dirA = 4'd9; dirB = 4'd5;
        tick(); idle();
        check("bypass_part_A", datA, 32'hAA345678);
        check("bypass_part_B", datB, 32'h11BB33DD);

        // zero register, including the bypass cycle
        reg_write = 1; dir_WR = 4'd0; data_in = 32'hFFFFFFFF; wr_be = 4'hF;
        rd_en = 1; dirA = 4'd0; dirB = 4'd9;
        tick(); idle();
        check("zero_bypass", datA, 32'h0);
        check("nz_bypass", datA_nz, 32'hFFFFFFFF);
        rd(4'd0, 4'd0);
        check("zero_stored", datA, 32'h0);
        check("nz_stored", datB_nz, 32'hFFFFFFFF);

        // bulk clear: busy length, dropped write during busy, all zero after
        for (int i = 0; i < 16; i++) wr(4'(i), 32'h01010101 * (i + 1), 4'hF);
        rd(4'd2, 4'd15);
        check("fill_2", datA, 32'h03030303);
        clr_req = 1;
        tick(); idle();
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (n == 10) begin
                reg_write = 1; dir_WR = 4'd2; data_in = 32'hCAFEF00D; wr_be = 4'hF;
                rd_en = 1; dirA = 4'd2; dirB = 4'd2;
            end else begin
                idle();
            end
            n++;
            tick();
            if (n == 11) begin
                check("busy_rd_valid", {31'b0, rd_valid}, 32'h0);
                check("busy_hold", datA, 32'h03030303);
            end
        end
        idle();
        check("clear_len", n, 16);
        for (int i = 0; i < 16; i += 2) begin
            rd(4'(i), 4'(i + 1));
            check($sformatf("clr_r%0d", i), datA, 32'h0);
            check($sformatf("clr_r%0d", i + 1), datB, 32'h0);
        end
        rd(4'd0, 4'd2);
        check("clr_nz_r0", datA_nz, 32'h0);

        // reset in the middle of a clear, then a full clear again
        for (int i = 0; i < 16; i++) wr(4'(i), 32'h5A5A0000 + i, 4'hF);
        clr_req = 1;
        tick(); idle();
        repeat (5) tick();
        check("mid_busy_pre", {31'b0, busy}, 32'h1);
        #2 rst_n = 0;
        #1;
        check("mid_busy_async", {31'b0, busy}, 32'h0);
        tick();
        rst_n = 1;
        tick();
        rd(4'd12, 4'd15);
        check("mid_r12", datA, 32'h0);
        check("mid_r15", datB, 32'h0);
        wr(4'd7, 32'h77777777, 4'hF);
        clr_req = 1;
        tick(); idle();
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check("reclear_len", n, 16);
        rd(4'd7, 4'd1);
        check("reclear_r7", datA, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
